// File: rtl/regfile_pkg.sv
// Shared widths, index helpers and the register-index type for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W    = 32;
    localparam int unsigned DEFAULT_REG_COUNT = 16;
    localparam int unsigned DEFAULT_NUM_RD    = 2;
    localparam int unsigned DEFAULT_BYPASS    = 1;

    function automatic int unsigned addr_w(input int unsigned reg_count);
        return (reg_count > 1) ? $clog2(reg_count) : 1;
    endfunction

    // The top architectural index is the PC and has no storage behind it.
    function automatic int unsigned pc_idx(input int unsigned reg_count);
        return reg_count - 1;
    endfunction

    localparam int unsigned DEFAULT_AW = addr_w(DEFAULT_REG_COUNT);

    typedef logic [DEFAULT_AW-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load busy bits: set on load issue, cleared by load writeback, set wins on collision.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned REG_COUNT = DEFAULT_REG_COUNT,
    parameter int unsigned NUM_RD    = DEFAULT_NUM_RD,
    parameter int unsigned BYPASS    = DEFAULT_BYPASS,
    localparam int unsigned AW       = addr_w(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   busy_set,
    input  logic [AW-1:0]          busy_addr,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr1,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [REG_COUNT-1:0]   busy_vec,
    output logic [NUM_RD-1:0]      rd_busy
);

    localparam int unsigned PC_IDX = pc_idx(REG_COUNT);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // Clear first so a new load issued to the returning destination keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (we1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (busy_set) begin
            busy_d[busy_addr] = 1'b1;
        end
        busy_d[PC_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // A load returning this cycle resolves the stall immediately when bypass is on.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
        logic [AW-1:0] ra;
        assign ra          = raddr[gi*AW +: AW];
        assign rd_busy[gi] = busy_q[ra] & ~((BYPASS != 0) && we1 && (waddr1 == ra));
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port ARM-style register file: two write ports, combinational reads with
// optional write bypass, PC index returning pc_in, and a pending-load scoreboard.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned REG_COUNT = DEFAULT_REG_COUNT,
    parameter int unsigned NUM_RD    = DEFAULT_NUM_RD,
    parameter int unsigned BYPASS    = DEFAULT_BYPASS,
    localparam int unsigned AW       = addr_w(REG_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we0,
    input  logic [AW-1:0]              waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [AW-1:0]              waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*AW-1:0]       raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic                       busy_set,
    input  logic [AW-1:0]              busy_addr,
    output logic [REG_COUNT-1:0]       busy_vec
);

    localparam int unsigned NUM_STORE = REG_COUNT - 1;
    localparam logic [AW-1:0] PC_ADDR = AW'(pc_idx(REG_COUNT));

    logic [DATA_W-1:0] regs_q [NUM_STORE];
    logic [DATA_W-1:0] regs_d [NUM_STORE];

    // Port 0 is applied last so it wins a same-index collision; PC writes never match.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned r = 0; r < NUM_STORE; r++) begin
            if (we1 && (waddr1 == AW'(r))) begin
                regs_d[r] = wdata1;
            end
            if (we0 && (waddr0 == AW'(r))) begin
                regs_d[r] = wdata0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_STORE; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read priority, lowest first: stored, port-1 bypass, port-0 bypass, PC.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[gi*AW +: AW];

        always_comb begin
            rd = '0;
            for (int unsigned r = 0; r < NUM_STORE; r++) begin
                if (ra == AW'(r)) begin
                    rd = regs_q[r];
                end
            end
            if ((BYPASS != 0) && we1 && (waddr1 == ra)) begin
                rd = wdata1;
            end
            if ((BYPASS != 0) && we0 && (waddr0 == ra)) begin
                rd = wdata0;
            end
            if (ra == PC_ADDR) begin
                rd = pc_in;
            end
        end

        assign rdata[gi*DATA_W +: DATA_W] = rd;
    end

    reg_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .NUM_RD    (NUM_RD),
        .BYPASS    (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .we1       (we1),
        .waddr1    (waddr1),
        .raddr     (raddr),
        .busy_vec  (busy_vec),
        .rd_busy   (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default build, a BYPASS=0 twin on the same
// inputs, and a 32-entry 4-read-port build.
module tb_reg_file_mp;

    logic        clk;
    logic        rst_n;
    logic        we0, we1, busy_set;
    logic [3:0]  waddr0, waddr1, busy_addr;
    logic [31:0] wdata0, wdata1, pc_in;
    logic [7:0]  raddr;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [15:0] busy_vec_a, busy_vec_b;

    logic         c_we0, c_we1, c_busy_set;
    logic [4:0]   c_waddr0, c_waddr1, c_busy_addr;
    logic [31:0]  c_wdata0, c_wdata1, c_pc;
    logic [19:0]  c_raddr;
    logic [127:0] c_rdata;
    logic [3:0]   c_rd_busy;
    logic [31:0]  c_busy_vec;

    int checks = 0;
    int passed = 0;

    reg_file_mp #(.DATA_W(32), .REG_COUNT(16), .NUM_RD(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_a), .rd_busy(rd_busy_a),
        .pc_in(pc_in), .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_vec(busy_vec_a)
    );

    reg_file_mp #(.DATA_W(32), .REG_COUNT(16), .NUM_RD(2), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b), .rd_busy(rd_busy_b),
        .pc_in(pc_in), .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_vec(busy_vec_b)
    );

    reg_file_mp #(.DATA_W(32), .REG_COUNT(32), .NUM_RD(4), .BYPASS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .we0(c_we0), .waddr0(c_waddr0), .wdata0(c_wdata0),
        .we1(c_we1), .waddr1(c_waddr1), .wdata1(c_wdata1),
        .raddr(c_raddr), .rdata(c_rdata), .rd_busy(c_rd_busy),
        .pc_in(c_pc), .busy_set(c_busy_set), .busy_addr(c_busy_addr),
        .busy_vec(c_busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; busy_set = 0;
        waddr0 = 0; waddr1 = 0; busy_addr = 0;
        wdata0 = 0; wdata1 = 0;
        c_we0 = 0; c_we1 = 0; c_busy_set = 0;
        c_waddr0 = 0; c_waddr1 = 0; c_busy_addr = 0;
        c_wdata0 = 0; c_wdata1 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        raddr = 8'h00; pc_in = 32'h0; c_raddr = '0; c_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_vec_a !== 16'h0) $display("FAIL reset_busy_vec: got %h want %h", busy_vec_a, 16'h0); else passed++;
        rst_n = 1;
        tick();
        we0 = 1; waddr0 = 4'd3; wdata0 = 32'h1234;
        busy_set = 1; busy_addr = 4'd3;
        tick();
        idle();
        raddr = {4'd15, 4'd3}; pc_in = 32'h55;
        #1;
        checks++; if (rdata_a[31:0] !== 32'h1234) $display("FAIL reset_pre_r3: got %h want %h", rdata_a[31:0], 32'h1234); else passed++;
        checks++; if (rd_busy_a !== 2'b01) $display("FAIL reset_pre_rd_busy: got %b want %b", rd_busy_a, 2'b01); else passed++;
        #1 rst_n = 0;
        #1;
        checks++; if (rdata_a[31:0] !== 32'h0) $display("FAIL reset_async_r3: got %h want %h", rdata_a[31:0], 32'h0); else passed++;
        checks++; if (rdata_a[63:32] !== 32'h55) $display("FAIL reset_async_pc: got %h want %h", rdata_a[63:32], 32'h55); else passed++;
        checks++; if (busy_vec_a !== 16'h0) $display("FAIL reset_async_busy_vec: got %h want %h", busy_vec_a, 16'h0); else passed++;
        checks++; if (rd_busy_a !== 2'b00) $display("FAIL reset_async_rd_busy: got %b want %b", rd_busy_a, 2'b00); else passed++;
        #1 rst_n = 1;
        tick();
    endtask

    task automatic test_basic_rw();
        idle();
        we0 = 1; waddr0 = 4'd5; wdata0 = 32'hDEADBEEF;
        tick();
        idle();
        raddr = {4'd15, 4'd5}; pc_in = 32'h108;
        #1;
        checks++; if (rdata_a[31:0] !== 32'hDEADBEEF) $display("FAIL basic_r5: got %h want %h", rdata_a[31:0], 32'hDEADBEEF); else passed++;
        checks++; if (rdata_a[63:32] !== 32'h108) $display("FAIL basic_pc: got %h want %h", rdata_a[63:32], 32'h108); else passed++;
        checks++; if (rdata_b[31:0] !== 32'hDEADBEEF) $display("FAIL basic_r5_nobyp: got %h want %h", rdata_b[31:0], 32'hDEADBEEF); else passed++;
        we0 = 1; waddr0 = 4'd15; wdata0 = 32'hFFFF;
        we1 = 1; waddr1 = 4'd15; wdata1 = 32'hEEEE;
        busy_set = 1; busy_addr = 4'd15;
        #1;
        checks++; if (rdata_a[63:32] !== 32'h108) $display("FAIL pc_write_same_cycle: got %h want %h", rdata_a[63:32], 32'h108); else passed++;
        tick();
        idle();
        #1;
        checks++; if (rdata_a[63:32] !== 32'h108) $display("FAIL pc_write_after: got %h want %h", rdata_a[63:32], 32'h108); else passed++;
        checks++; if (busy_vec_a !== 16'h0) $display("FAIL pc_busy_ignored: got %h want %h", busy_vec_a, 16'h0); else passed++;
    endtask

    task automatic test_bypass();
        idle();
        raddr = {4'd9, 4'd2};
        we0 = 1; waddr0 = 4'd2; wdata0 = 32'hAA;
        we1 = 1; waddr1 = 4'd9; wdata1 = 32'h77;
        #1;
        checks++; if (rdata_a[31:0] !== 32'hAA) $display("FAIL bypass_we0: got %h want %h", rdata_a[31:0], 32'hAA); else passed++;
        checks++; if (rdata_a[63:32] !== 32'h77) $display("FAIL bypass_we1: got %h want %h", rdata_a[63:32], 32'h77); else passed++;
        checks++; if (rdata_b[31:0] !== 32'h0) $display("FAIL nobypass_old_r2: got %h want %h", rdata_b[31:0], 32'h0); else passed++;
        checks++; if (rdata_b[63:32] !== 32'h0) $display("FAIL nobypass_old_r9: got %h want %h", rdata_b[63:32], 32'h0); else passed++;
        tick();
        idle();
        #1;
        checks++; if (rdata_b[31:0] !== 32'hAA) $display("FAIL nobypass_next_r2: got %h want %h", rdata_b[31:0], 32'hAA); else passed++;
        checks++; if (rdata_b[63:32] !== 32'h77) $display("FAIL nobypass_next_r9: got %h want %h", rdata_b[63:32], 32'h77); else passed++;
    endtask

    task automatic test_dual_write();
        idle();
        busy_set = 1; busy_addr = 4'd7;
        tick();
        idle();
        raddr = {4'd0, 4'd7};
        we0 = 1; waddr0 = 4'd7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 4'd7; wdata1 = 32'h22;
        #1;
        checks++; if (rdata_a[31:0] !== 32'h11) $display("FAIL dual_bypass_prio: got %h want %h", rdata_a[31:0], 32'h11); else passed++;
        checks++; if (rd_busy_a[0] !== 1'b0) $display("FAIL dual_rd_busy_masked: got %b want %b", rd_busy_a[0], 1'b0); else passed++;
        checks++; if (rd_busy_b[0] !== 1'b1) $display("FAIL dual_rd_busy_nobyp: got %b want %b", rd_busy_b[0], 1'b1); else passed++;
        tick();
        idle();
        #1;
        checks++; if (rdata_b[31:0] !== 32'h11) $display("FAIL dual_stored_r7: got %h want %h", rdata_b[31:0], 32'h11); else passed++;
        checks++; if (busy_vec_a !== 16'h0) $display("FAIL dual_busy_cleared: got %h want %h", busy_vec_a, 16'h0); else passed++;
    endtask

    task automatic test_scoreboard();
        idle();
        busy_set = 1; busy_addr = 4'd4;
        tick();
        idle();
        raddr = {4'd0, 4'd4};
        #1;
        checks++; if (busy_vec_a !== 16'h0010) $display("FAIL sb_busy_vec_r4: got %h want %h", busy_vec_a, 16'h0010); else passed++;
        checks++; if (rd_busy_a !== 2'b01) $display("FAIL sb_rd_busy_r4: got %b want %b", rd_busy_a, 2'b01); else passed++;
        we1 = 1; waddr1 = 4'd4; wdata1 = 32'h99;
        #1;
        checks++; if (rd_busy_a[0] !== 1'b0) $display("FAIL sb_return_rd_busy: got %b want %b", rd_busy_a[0], 1'b0); else passed++;
        checks++; if (rdata_a[31:0] !== 32'h99) $display("FAIL sb_return_data: got %h want %h", rdata_a[31:0], 32'h99); else passed++;
        tick();
        idle();
        #1;
        checks++; if (busy_vec_a !== 16'h0) $display("FAIL sb_after_return: got %h want %h", busy_vec_a, 16'h0); else passed++;
        checks++; if (rdata_b[31:0] !== 32'h99) $display("FAIL sb_stored_r4: got %h want %h", rdata_b[31:0], 32'h99); else passed++;
        busy_set = 1; busy_addr = 4'd10;
        tick();
        idle();
        we0 = 1; waddr0 = 4'd10; wdata0 = 32'hA0A0;
        tick();
        idle();
        raddr = {4'd0, 4'd10};
        #1;
        checks++; if (busy_vec_a !== 16'h0400) $display("FAIL sb_we0_keeps_busy: got %h want %h", busy_vec_a, 16'h0400); else passed++;
        checks++; if (rdata_b[31:0] !== 32'hA0A0) $display("FAIL sb_we0_data: got %h want %h", rdata_b[31:0], 32'hA0A0); else passed++;
    endtask

    task automatic test_collision();
        idle();
        busy_set = 1; busy_addr = 4'd6;
        we1 = 1; waddr1 = 4'd6; wdata1 = 32'h66;
        tick();
        idle();
        raddr = {4'd0, 4'd6};
        #1;
        checks++; if (busy_vec_a !== 16'h0440) $display("FAIL coll_set_wins: got %h want %h", busy_vec_a, 16'h0440); else passed++;
        checks++; if (rdata_a[31:0] !== 32'h66) $display("FAIL coll_data: got %h want %h", rdata_a[31:0], 32'h66); else passed++;
        checks++; if (rd_busy_a !== 2'b01) $display("FAIL coll_rd_busy: got %b want %b", rd_busy_a, 2'b01); else passed++;
    endtask

    task automatic test_wide();
        idle();
        c_we0 = 1; c_waddr0 = 5'd17; c_wdata0 = 32'hCAFE;
        c_we1 = 1; c_waddr1 = 5'd30; c_wdata1 = 32'hBEEF;
        c_busy_set = 1; c_busy_addr = 5'd20;
        tick();
        idle();
        c_we0 = 1; c_waddr0 = 5'd31; c_wdata0 = 32'h1;
        c_busy_set = 1; c_busy_addr = 5'd31;
        tick();
        idle();
        c_raddr = {5'd31, 5'd20, 5'd30, 5'd17};
        c_pc = 32'h2000;
        #1;
        checks++; if (c_rdata[31:0] !== 32'hCAFE) $display("FAIL wide_r17: got %h want %h", c_rdata[31:0], 32'hCAFE); else passed++;
        checks++; if (c_rdata[63:32] !== 32'hBEEF) $display("FAIL wide_r30: got %h want %h", c_rdata[63:32], 32'hBEEF); else passed++;
        checks++; if (c_rdata[95:64] !== 32'h0) $display("FAIL wide_r20: got %h want %h", c_rdata[95:64], 32'h0); else passed++;
        checks++; if (c_rdata[127:96] !== 32'h2000) $display("FAIL wide_pc: got %h want %h", c_rdata[127:96], 32'h2000); else passed++;
        checks++; if (c_rd_busy !== 4'b0100) $display("FAIL wide_rd_busy: got %b want %b", c_rd_busy, 4'b0100); else passed++;
        checks++; if (c_busy_vec !== 32'h0010_0000) $display("FAIL wide_busy_vec: got %h want %h", c_busy_vec, 32'h0010_0000); else passed++;
        c_we1 = 1; c_waddr1 = 5'd20; c_wdata1 = 32'h5;
        #1;
        checks++; if (c_rd_busy !== 4'b0000) $display("FAIL wide_return_rd_busy: got %b want %b", c_rd_busy, 4'b0000); else passed++;
        checks++; if (c_rdata[95:64] !== 32'h5) $display("FAIL wide_return_data: got %h want %h", c_rdata[95:64], 32'h5); else passed++;
        tick();
        idle();
        #1;
        checks++; if (c_busy_vec !== 32'h0) $display("FAIL wide_busy_cleared: got %h want %h", c_busy_vec, 32'h0); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_collision();
        test_wide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
